move_sequencer: RTL and testbench

Sequences player moves into the 2048 board engine. Synchronizes and debounces the four raw direction buttons. Picks one direction per press with fixed priority and hands it to the board engine over a valid/ready handshake. Accepts no new move until the engine reports completion and all buttons are released. Sits between the board-level button pins and the game logic, in place of direct button wiring.

---
 rtl/move_sequencer.sv | 162 ++++++++++++++++
 tb/tb_move_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Purpose: debounces four direction buttons and hands one move per press to the board engine.
// Latency: a clean press shows up as move_valid DEBOUNCE_CYCLES+2 edges after the first sampling edge.
// Backpressure: move_valid/move_dir hold until move_ready; no new move until move_done and all buttons released.
module move_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        game_over,
  input  logic        move_ready,
  input  logic        move_done,
  output logic        move_valid,
  output logic [1:0]  move_dir,
  output logic        busy,
  output logic [15:0] move_count
);

  // Counter value at which a level change has been stable long enough.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  // Buttons packed by priority: bit 0 = up, 1 = down, 2 = left, 3 = right.
  logic [3:0] btn_raw;
  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchronizer chain per button.
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  // Debounced level, its one-cycle delayed copy and the stability counters.
  logic [3:0]            db_q, db_d;
  logic [3:0]            db_dly_q, db_dly_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            rise;

  // Sequencer state and registered outputs.
  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [1:0]  dir_q, dir_d;
  logic        busy_q, busy_d;
  logic [15:0] count_q, count_d;

  // Synchronizer next values: simply shift the raw level down the chain.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_dly_d = db_q;
  end

  // Debounce: a differing level must persist for DEBOUNCE_CYCLES samples; any bounce restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = ~db_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // A press is the debounced level going high; releases are not of interest.
  assign rise = db_q & ~db_dly_q;

  // Next-state and registered-output logic for the move handshake.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        // Rises seen here are the only ones that can start a move; game_over suppresses them.
        if ((rise != 4'b0000) && !game_over) begin
          state_d = REQ;
          if (rise[0])      dir_d = 2'b00;
          else if (rise[1]) dir_d = 2'b01;
          else if (rise[2]) dir_d = 2'b10;
          else              dir_d = 2'b11;
        end
      end
      REQ: begin
        // move_valid is high throughout REQ, so ready alone completes the handshake.
        if (move_ready) begin
          state_d = WAIT_DONE;
          count_d = count_q + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (move_done) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Require every button up so one long press cannot produce a second move.
        if (db_q == 4'b0000) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == REQ);
    busy_d  = (state_d != IDLE);
  end

  // Synchronizer and debounce registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
    end
  end

  // Sequencer state and output registers; reset abandons any move in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      dir_q   <= 2'b00;
      busy_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign move_valid = valid_q;
  assign move_dir   = dir_q;
  assign busy       = busy_q;
  assign move_count = count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer with a short debounce window.
// Every cycle is compared against a transaction-level model; directed tables and sequences add fixed expectations.
// The bench also plays the board engine (ready/done) and the player (buttons).
module tb_move_sequencer;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  raw;   // 0=up 1=down 2=left 3=right
  logic        go, rdy, done;
  logic        mv;
  logic [1:0]  md;
  logic        bz;
  logic [15:0] mc;

  always #5 clk = ~clk;

  move_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .btn_up(raw[0]), .btn_down(raw[1]), .btn_left(raw[2]), .btn_right(raw[3]),
    .game_over(go), .move_ready(rdy), .move_done(done),
    .move_valid(mv), .move_dir(md), .busy(bz), .move_count(mc)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_moves;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw samples per button, newest at index 0. Debounced level flips once the last DB
  // synchronized samples (two edges old and older) all disagree with it.
  bit          h [4][DB+1];
  bit [3:0]    m_db, m_dbd;
  bit          m_pend, m_fly, m_rel;   // request outstanding / engine working / waiting for release
  bit [1:0]    m_dir;
  bit [15:0]   m_cnt;

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i <= DB; i++) h[b][i] = 1'b0;
    m_db = '0; m_dbd = '0;
    m_pend = 0; m_fly = 0; m_rel = 0;
    m_dir = 2'b00; m_cnt = 16'd0;
  endtask

  task automatic model_edge();
    bit [3:0] press;
    bit [3:0] nxt;
    bit       flip;
    if (!rst) begin
      model_reset();
      return;
    end
    press = m_db & ~m_dbd;
    nxt   = m_db;
    if (m_pend) begin
      if (rdy) begin m_pend = 0; m_fly = 1; m_cnt = m_cnt + 16'd1; end
    end else if (m_fly) begin
      if (done) begin m_fly = 0; m_rel = 1; end
    end else if (m_rel) begin
      if (m_db == 4'b0000) m_rel = 0;
    end else if (press != 4'b0000 && !go) begin
      m_pend = 1;
      for (int b = 3; b >= 0; b--) if (press[b]) m_dir = 2'(b);
    end
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int i = 1; i <= DB; i++) if (h[b][i] == m_db[b]) flip = 1'b0;
      if (flip) nxt[b] = ~m_db[b];
      for (int i = DB; i >= 1; i--) h[b][i] = h[b][i-1];
      h[b][0] = raw[b];
    end
    m_dbd = m_db;
    m_db  = nxt;
  endtask

  task automatic compare_all();
    chk("model_valid", mv, m_pend);
    chk("model_busy",  bz, m_pend | m_fly | m_rel);
    chk("model_dir",   md, m_dir);
    chk("model_count", mc, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_valid(input int max, output bit seen);
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (mv) seen = 1;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (!bz) ok = 1;
    end
    chk(nm, ok, 1);
  endtask

  task automatic pulse_done();
    done = 1; tick(); done = 0;
  endtask

  typedef struct {
    logic [3:0] btns;
    logic       gov;
    logic       exp_req;
    logic [1:0] exp_dir;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[8];
    bit   seen, seen2;

    rst = 0; raw = '0; go = 0; rdy = 0; done = 0; exp_moves = 16'd0;
    model_reset();
    repeat (3) tick();
    chk("rst_valid", mv, 0);
    chk("rst_busy", bz, 0);
    chk("rst_dir", md, 0);
    chk("rst_count", mc, 0);
    rst = 1;
    repeat (2) tick();

    // ---- table: priority and game_over ----
    tab[0] = '{4'b0001, 1'b0, 1'b1, 2'b00};
    tab[1] = '{4'b0010, 1'b0, 1'b1, 2'b01};
    tab[2] = '{4'b0100, 1'b0, 1'b1, 2'b10};
    tab[3] = '{4'b1000, 1'b0, 1'b1, 2'b11};
    tab[4] = '{4'b1010, 1'b0, 1'b1, 2'b01};
    tab[5] = '{4'b1111, 1'b0, 1'b1, 2'b00};
    tab[6] = '{4'b1100, 1'b0, 1'b1, 2'b10};
    tab[7] = '{4'b0001, 1'b1, 1'b0, 2'b00};
    for (int t = 0; t < 8; t++) begin
      go = tab[t].gov; rdy = 1; raw = tab[t].btns;
      wait_valid(12, seen);
      chk("tab_req", seen, tab[t].exp_req);
      if (seen) chk("tab_dir", md, tab[t].exp_dir);
      if (tab[t].exp_req) exp_moves = exp_moves + 16'd1;
      tick();
      pulse_done();
      raw = '0; go = 0;
      wait_idle("tab_idle");
      repeat (8) tick();
      chk("tab_count", mc, exp_moves);
    end

    // ---- clean press: exact latency, one-cycle valid ----
    rdy = 1; raw = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("lat_valid", mv, (k == 6));
    end
    exp_moves = exp_moves + 16'd1;
    chk("lat_dir", md, 2'b10);
    chk("lat_count", mc, exp_moves);
    pulse_done();
    chk("lat_held_busy", bz, 1);
    raw = '0;
    wait_idle("lat_idle");
    repeat (8) tick();

    // ---- bounce rejection ----
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      raw[0] = ((k / 2) % 2 == 0);
      tick();
      if (mv) seen = 1;
    end
    raw = '0;
    repeat (10) begin tick(); if (mv) seen = 1; end
    chk("bounce_valid", seen, 0);
    chk("bounce_count", mc, exp_moves);

    // ---- priority then discard of a press during WAIT_DONE ----
    rdy = 1; raw = 4'b1010;
    wait_valid(12, seen);
    chk("prio_seen", seen, 1);
    chk("prio_dir", md, 2'b01);
    tick();
    exp_moves = exp_moves + 16'd1;
    raw = 4'b0001;
    seen2 = 0;
    repeat (10) begin tick(); if (mv) seen2 = 1; end
    raw = '0;
    repeat (8) begin tick(); if (mv) seen2 = 1; end
    pulse_done();
    repeat (20) begin tick(); if (mv) seen2 = 1; end
    chk("discard_valid", seen2, 0);
    chk("discard_count", mc, exp_moves);
    chk("discard_busy", bz, 0);

    // ---- backpressure: 10 cycles not ready, done during REQ ignored ----
    rdy = 0; raw = 4'b0001;
    wait_valid(12, seen);
    chk("bp_seen", seen, 1);
    for (int k = 0; k < 9; k++) begin
      if (k == 4) done = 1;
      tick();
      done = 0;
      chk("bp_valid", mv, 1);
      chk("bp_dir", md, 2'b00);
    end
    rdy = 1;
    tick();
    exp_moves = exp_moves + 16'd1;
    chk("bp_drop", mv, 0);
    chk("bp_count", mc, exp_moves);
    raw = '0;
    repeat (10) tick();
    chk("bp_done_ignored", bz, 1);
    pulse_done();
    wait_idle("bp_idle");
    repeat (8) tick();

    // ---- held button keeps RELEASE ----
    rdy = 1; raw = 4'b0001;
    wait_valid(12, seen);
    chk("held_seen", seen, 1);
    tick();
    exp_moves = exp_moves + 16'd1;
    pulse_done();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("held_busy", bz, 1);
      chk("held_valid", mv, 0);
    end
    raw = '0;
    wait_idle("held_idle");
    repeat (8) tick();

    // ---- count wrap ----
    force dut.count_q = 16'hFFFF;
    m_cnt = 16'hFFFF; exp_moves = 16'hFFFF;
    tick();
    release dut.count_q;
    tick();
    chk("wrap_pre", mc, 16'hFFFF);
    rdy = 1; raw = 4'b1000;
    wait_valid(12, seen);
    tick();
    exp_moves = exp_moves + 16'd1;
    chk("wrap_count", mc, exp_moves);
    chk("wrap_zero", mc, 16'h0000);
    pulse_done();
    raw = '0;
    wait_idle("wrap_idle");
    repeat (8) tick();

    // ---- async reset during WAIT_DONE ----
    rdy = 1; raw = 4'b0100;
    wait_valid(12, seen);
    tick();
    chk("rstw_busy_before", bz, 1);
    #2;
    rst = 0;
    #1;
    model_reset();
    exp_moves = 16'd0;
    chk("rstw_valid", mv, 0);
    chk("rstw_busy", bz, 0);
    chk("rstw_dir", md, 2'b00);
    chk("rstw_count", mc, 16'd0);
    raw = '0;
    tick();
    rst = 1;
    repeat (8) tick();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0)
        raw = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 30) == 0)
        raw[$urandom_range(0, 3)] = ~raw[$urandom_range(0, 3)];
      rdy  = 1'($urandom_range(0, 1));
      done = m_fly ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0) go = ~go;
      tick();
    end
    chk("rand_active", (mc != 16'd0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
